sel_addsub_unit: RTL and testbench

//  Registered select/add/subtract datapath: four independent result lanes,

---
 rtl/sel_addsub_unit.sv | 127 ++++++++++++
 tb/tb_sel_addsub_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sel_addsub_unit.sv
// Registered select/add/subtract datapath: four independent result lanes with 1-cycle latency.
// Optional carry/borrow flag outputs are enabled by defining SEL_ADDSUB_FLAGS_EN.
module sel_addsub_unit #(
    parameter int AB_W = 9,
    parameter int CD_W = 3,
    parameter int O2_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s,
    input  logic [AB_W-1:0] a,
    input  logic [AB_W-1:0] b,
    input  logic [CD_W-1:0] c,
    input  logic [CD_W-1:0] d,
    output logic [AB_W-1:0] o1,
    output logic [O2_W-1:0] o2,
    output logic [CD_W-1:0] o3,
    output logic [CD_W-1:0] o4
`ifdef SEL_ADDSUB_FLAGS_EN
    ,
    output logic            o1_cy,
    output logic            o4_bw
`endif
);

    logic [AB_W-1:0] w_ab_sum;
    logic [O2_W-1:0] w_ab_diff;
    logic [CD_W-1:0] w_cd_sum;
    logic [CD_W-1:0] w_cd_diff;

    logic [AB_W-1:0] w_o1_nxt;
    logic [O2_W-1:0] w_o2_nxt;
    logic [CD_W-1:0] w_o3_nxt;
    logic [CD_W-1:0] w_o4_nxt;

    logic [AB_W-1:0] r_o1;
    logic [O2_W-1:0] r_o2;
    logic [CD_W-1:0] r_o3;
    logic [CD_W-1:0] r_o4;

    // Only the low O2_W bits of a and b ever reach o2, so the subtract is kept narrow.
    assign w_ab_diff = a[O2_W-1:0] - b[O2_W-1:0];
    assign w_cd_sum  = d + c;

`ifdef SEL_ADDSUB_FLAGS_EN
    logic w_cy;
    logic w_bw;
    logic w_cy_nxt;
    logic w_bw_nxt;
    logic r_cy;
    logic r_bw;

    // The extra MSB of the widened add/subtract is the carry or borrow.
    assign {w_cy, w_ab_sum}  = {1'b0, a} + {1'b0, b};
    assign {w_bw, w_cd_diff} = {1'b0, c} - {1'b0, d};

    // Flags are forced low in pass/constant mode.
    always_comb begin
        w_cy_nxt = 1'b0;
        w_bw_nxt = 1'b0;
        if (s) begin
            w_cy_nxt = 1'b0;
            w_bw_nxt = 1'b0;
        end else begin
            w_cy_nxt = w_cy;
            w_bw_nxt = w_bw;
        end
    end

    // Flag registers share the datapath's reset and latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cy <= 1'b0;
            r_bw <= 1'b0;
        end else begin
            r_cy <= w_cy_nxt;
            r_bw <= w_bw_nxt;
        end
    end

    assign o1_cy = r_cy;
    assign o4_bw = r_bw;
`else
    assign w_ab_sum  = a + b;
    assign w_cd_diff = c - d;
`endif

    // Lane select: arithmetic results when s=0, pass/constant values when s=1.
    always_comb begin
        w_o1_nxt = {AB_W{1'b0}};
        w_o2_nxt = {O2_W{1'b0}};
        w_o3_nxt = {CD_W{1'b0}};
        w_o4_nxt = {CD_W{1'b0}};
        if (s) begin
            w_o1_nxt = {AB_W{1'b0}};
            w_o2_nxt = a[O2_W-1:0];
            w_o3_nxt = {CD_W{1'b1}};
            w_o4_nxt = d;
        end else begin
            w_o1_nxt = w_ab_sum;
            w_o2_nxt = w_ab_diff;
            w_o3_nxt = w_cd_sum;
            w_o4_nxt = w_cd_diff;
        end
    end

    // Result registers; asynchronous reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o1 <= {AB_W{1'b0}};
            r_o2 <= {O2_W{1'b0}};
            r_o3 <= {CD_W{1'b0}};
            r_o4 <= {CD_W{1'b0}};
        end else begin
            r_o1 <= w_o1_nxt;
            r_o2 <= w_o2_nxt;
            r_o3 <= w_o3_nxt;
            r_o4 <= w_o4_nxt;
        end
    end

    assign o1 = r_o1;
    assign o2 = r_o2;
    assign o3 = r_o3;
    assign o4 = r_o4;

endmodule

// File: tb/tb_sel_addsub_unit.sv
// Self-checking bench for sel_addsub_unit: directed cases, a long s-toggling sweep,
// random traffic and mid-stream reset, all checked against an integer reference model.
module tb_sel_addsub_unit;
    localparam int AB_W = 9;
    localparam int CD_W = 3;
    localparam int O2_W = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            s;
    logic [AB_W-1:0] a;
    logic [AB_W-1:0] b;
    logic [CD_W-1:0] c;
    logic [CD_W-1:0] d;
    logic [AB_W-1:0] o1;
    logic [O2_W-1:0] o2;
    logic [CD_W-1:0] o3;
    logic [CD_W-1:0] o4;
`ifdef SEL_ADDSUB_FLAGS_EN
    logic            o1_cy;
    logic            o4_bw;
`endif

    int checks = 0;
    int errors = 0;

    sel_addsub_unit #(.AB_W(AB_W), .CD_W(CD_W), .O2_W(O2_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .o1    (o1),
        .o2    (o2),
        .o3    (o3),
        .o4    (o4)
`ifdef SEL_ADDSUB_FLAGS_EN
        ,
        .o1_cy (o1_cy),
        .o4_bw (o4_bw)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: plain modular integer arithmetic on the sampled inputs.
    task automatic expect_model(input string tag, input int ms, input int ma, input int mb,
                                input int mc, input int md);
        int m_ab;
        int m_o2;
        int m_cd;
        m_ab = 1 << AB_W;
        m_o2 = 1 << O2_W;
        m_cd = 1 << CD_W;
        if (ms != 0) begin
            check_val({tag, ".o1"}, 32'(o1), 0);
            check_val({tag, ".o2"}, 32'(o2), ma % m_o2);
            check_val({tag, ".o3"}, 32'(o3), m_cd - 1);
            check_val({tag, ".o4"}, 32'(o4), md);
        end else begin
            check_val({tag, ".o1"}, 32'(o1), (ma + mb) % m_ab);
            check_val({tag, ".o2"}, 32'(o2), (((ma - mb) % m_o2) + m_o2) % m_o2);
            check_val({tag, ".o3"}, 32'(o3), (md + mc) % m_cd);
            check_val({tag, ".o4"}, 32'(o4), (((mc - md) % m_cd) + m_cd) % m_cd);
        end
`ifdef SEL_ADDSUB_FLAGS_EN
        check_val({tag, ".cy"}, 32'(o1_cy), (ms == 0 && ma + mb >= m_ab) ? 1 : 0);
        check_val({tag, ".bw"}, 32'(o4_bw), (ms == 0 && mc < md) ? 1 : 0);
`endif
    endtask

    task automatic expect_zero(input string tag);
        check_val({tag, ".o1"}, 32'(o1), 0);
        check_val({tag, ".o2"}, 32'(o2), 0);
        check_val({tag, ".o3"}, 32'(o3), 0);
        check_val({tag, ".o4"}, 32'(o4), 0);
`ifdef SEL_ADDSUB_FLAGS_EN
        check_val({tag, ".cy"}, 32'(o1_cy), 0);
        check_val({tag, ".bw"}, 32'(o4_bw), 0);
`endif
    endtask

    task automatic set_inputs(input int vs, input int va, input int vb, input int vc, input int vd);
        s = vs[0];
        a = va[AB_W-1:0];
        b = vb[AB_W-1:0];
        c = vc[CD_W-1:0];
        d = vd[CD_W-1:0];
    endtask

    // Drive on the falling edge, check 1 time unit after the following rising edge.
    task automatic step(input string tag, input int vs, input int va, input int vb,
                        input int vc, input int vd);
        @(negedge clk);
        set_inputs(vs, va, vb, vc, vd);
        @(posedge clk);
        #1;
        expect_model(tag, vs, va, vb, vc, vd);
    endtask

    initial begin
        int va;
        int vb;
        int vc;
        int vd;
        int vs;

        set_inputs(0, 300, 200, 5, 6);
        #2;
        rst_n = 1'b0;
        #1;
        expect_zero("rst_async");
        repeat (3) @(posedge clk);
        #1;
        expect_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        step("dir_arith", 0, 12, 33, 1, 6);
        step("dir_pass", 1, 13, 33, 1, 2);
        step("dir_wrap", 0, 511, 1, 7, 1);
        step("dir_borrow", 0, 0, 511, 0, 7);
        step("dir_pass_max", 1, 511, 511, 7, 7);

        va = 0; vb = 0; vc = 0; vd = 0; vs = 0;
        for (int i = 0; i < 10000; i++) begin
            step("sweep", vs, va, vb, vc, vd);
            vs = 1 - vs;
            va = (va + 12) % 512;
            vb = (vb + 33) % 512;
            vc = (vc + 17) % 8;
            vd = (vd + 22) % 8;
        end

        for (int i = 0; i < 300; i++) begin
            step("rand", int'($urandom_range(1, 0)), int'($urandom_range(511, 0)),
                 int'($urandom_range(511, 0)), int'($urandom_range(7, 0)),
                 int'($urandom_range(7, 0)));
        end

        step("pre_rst", 0, 100, 50, 3, 4);
        @(negedge clk);
        set_inputs(0, 77, 88, 2, 5);
        #1;
        rst_n = 1'b0;
        #1;
        expect_zero("mid_rst");
        @(posedge clk);
        #1;
        expect_zero("mid_rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        set_inputs(1, 77, 88, 2, 5);
        @(posedge clk);
        #1;
        expect_model("resume", 1, 77, 88, 2, 5);
        step("resume2", 0, 400, 300, 6, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
